// File: rtl/enlynx_evcnt_if.sv
// Snapshot hand-off bundle: the counter block offers a period snapshot,
// the consumer accepts it with snap_ready_i.
interface enlynx_evcnt_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32
);
   logic                           snap_valid_o;
   logic                           snap_ready_i;
   logic [NUM_CH-1:0][CNT_W-1:0]   snap_data_o;
   logic [NUM_CH-1:0]              snap_ovf_o;
   logic                           snap_lost_o;

   modport master (
      output snap_valid_o, snap_data_o, snap_ovf_o, snap_lost_o,
      input  snap_ready_i
   );

   modport slave (
      input  snap_valid_o, snap_data_o, snap_ovf_o, snap_lost_o,
      output snap_ready_i
   );
endinterface

// File: rtl/enlynx_evcnt.sv
// Multi-channel event counter with wrap/saturate overflow policy and an
// end-of-period snapshot offered over a valid/ready hand-off.

// One channel: live counter plus sticky overflow flag. cnt_nxt/ovf_nxt are
// the values the channel would take without a period restart; the top
// captures them into the snapshot on eop so the eop-cycle event is kept.
module enlynx_evcnt_lane #(
   parameter int CNT_W    = 32,
   parameter int SAT_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             eop,
   input  logic             clear,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic             ovf_nxt
);
   logic at_max;

   assign at_max = (cnt == {CNT_W{1'b1}});

   // Increment step: wrap to 0 or hold at max when full, flag overflow.
   always_comb begin
      cnt_nxt = cnt;
      ovf_nxt = ovf;
      if (inc) begin
         if (at_max) begin
            cnt_nxt = (SAT_MODE != 0) ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
            ovf_nxt = 1'b1;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   // Live state: period restart and clear both zero the channel.
   always_ff @(posedge clk) begin
      if (rst || eop || clear) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         ovf <= ovf_nxt;
      end
   end
endmodule

module enlynx_evcnt #(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 32,
   parameter int SAT_MODE = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             events_i,
   input  logic                          enable_cnt_i,
   input  logic [NUM_CH-1:0]             ch_mask_i,
   input  logic                          eop_i,
   input  logic                          clear_i,
   output logic [NUM_CH-1:0][CNT_W-1:0]  counters_o,
   output logic [NUM_CH-1:0]             overflow_o,
   enlynx_evcnt_if.master                snap
);
   logic [NUM_CH-1:0]            inc;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_nxt;
   logic [NUM_CH-1:0]            ovf_nxt;
   logic                         accept;

   assign inc    = {NUM_CH{enable_cnt_i}} & ch_mask_i & events_i;
   assign accept = snap.snap_valid_o & snap.snap_ready_i;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      enlynx_evcnt_lane #(
         .CNT_W    (CNT_W),
         .SAT_MODE (SAT_MODE)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .inc     (inc[g]),
         .eop     (eop_i),
         .clear   (clear_i),
         .cnt     (counters_o[g]),
         .ovf     (overflow_o[g]),
         .cnt_nxt (cnt_nxt[g]),
         .ovf_nxt (ovf_nxt[g])
      );
   end

   // Snapshot capture: only eop loads; otherwise held stable for the consumer.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap.snap_data_o <= '0;
         snap.snap_ovf_o  <= '0;
      end else if (eop_i) begin
         snap.snap_data_o <= cnt_nxt;
         snap.snap_ovf_o  <= ovf_nxt;
      end
   end

   // Valid: set by eop, dropped by an accepted hand-off; eop wins a tie.
   always_ff @(posedge clk) begin
      if (rst)
         snap.snap_valid_o <= 1'b0;
      else if (eop_i)
         snap.snap_valid_o <= 1'b1;
      else if (accept)
         snap.snap_valid_o <= 1'b0;
   end

   // Lost flag: an unconsumed snapshot got overwritten; clear wins over set.
   always_ff @(posedge clk) begin
      if (rst || clear_i)
         snap.snap_lost_o <= 1'b0;
      else if (eop_i && snap.snap_valid_o && !snap.snap_ready_i)
         snap.snap_lost_o <= 1'b1;
   end
endmodule

// File: tb/tb_enlynx_evcnt.sv
// Bench for enlynx_evcnt: three configurations share one stimulus stream
// (32-bit wrap, 4-bit wrap, 4-bit saturate) and are compared every cycle
// against an integer reference model, plus directed scenario checks.
module tb_enlynx_evcnt;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] ev, mask;
   logic       en, eop, clr, rdy;

   logic [1:0][31:0] cnt0;
   logic [1:0][3:0]  cnt1, cnt2;
   logic [1:0]       ovf0, ovf1, ovf2;

   int checks = 0;
   int errors = 0;

   // reference model state, index [dut][channel]
   longint m_cnt [3][2];
   bit     m_ovf [3][2];
   longint m_snap[3][2];
   bit     m_sovf[3][2];
   bit     m_vld [3];
   bit     m_lost[3];

   always #5 clk = ~clk;

   enlynx_evcnt_if #(.NUM_CH(2), .CNT_W(32)) s0 ();
   enlynx_evcnt_if #(.NUM_CH(2), .CNT_W(4))  s1 ();
   enlynx_evcnt_if #(.NUM_CH(2), .CNT_W(4))  s2 ();
   assign s0.snap_ready_i = rdy;
   assign s1.snap_ready_i = rdy;
   assign s2.snap_ready_i = rdy;

   enlynx_evcnt #(.NUM_CH(2), .CNT_W(32), .SAT_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .events_i(ev), .enable_cnt_i(en), .ch_mask_i(mask),
      .eop_i(eop), .clear_i(clr), .counters_o(cnt0), .overflow_o(ovf0), .snap(s0));
   enlynx_evcnt #(.NUM_CH(2), .CNT_W(4), .SAT_MODE(0)) dut1 (
      .clk(clk), .rst(rst), .events_i(ev), .enable_cnt_i(en), .ch_mask_i(mask),
      .eop_i(eop), .clear_i(clr), .counters_o(cnt1), .overflow_o(ovf1), .snap(s1));
   enlynx_evcnt #(.NUM_CH(2), .CNT_W(4), .SAT_MODE(1)) dut2 (
      .clk(clk), .rst(rst), .events_i(ev), .enable_cnt_i(en), .ch_mask_i(mask),
      .eop_i(eop), .clear_i(clr), .counters_o(cnt2), .overflow_o(ovf2), .snap(s2));

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance the model by one clock using the currently driven inputs.
   task automatic model_step();
      for (int d = 0; d < 3; d++) begin
         longint mx = (d == 0) ? 64'hFFFF_FFFF : 64'd15;
         bit     sat = (d == 2);
         bit     was_vld = m_vld[d];
         for (int c = 0; c < 2; c++) begin
            longint nc = m_cnt[d][c];
            bit     no = m_ovf[d][c];
            if (en && mask[c] && ev[c]) begin
               if (nc < mx) nc = nc + 1;
               else begin
                  nc = sat ? mx : 0;
                  no = 1;
               end
            end
            if (rst) begin
               m_cnt[d][c] = 0; m_ovf[d][c] = 0; m_snap[d][c] = 0; m_sovf[d][c] = 0;
            end else begin
               if (eop) begin
                  m_snap[d][c] = nc;
                  m_sovf[d][c] = no;
               end
               if (eop || clr) begin
                  m_cnt[d][c] = 0; m_ovf[d][c] = 0;
               end else begin
                  m_cnt[d][c] = nc; m_ovf[d][c] = no;
               end
            end
         end
         if (rst) begin
            m_vld[d] = 0; m_lost[d] = 0;
         end else begin
            if (eop) m_vld[d] = 1;
            else if (was_vld && rdy) m_vld[d] = 0;
            if (clr) m_lost[d] = 0;
            else if (eop && was_vld && !rdy) m_lost[d] = 1;
         end
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < 2; c++) begin
         chk($sformatf("d0_cnt%0d", c), cnt0[c], m_cnt[0][c]);
         chk($sformatf("d1_cnt%0d", c), cnt1[c], m_cnt[1][c]);
         chk($sformatf("d2_cnt%0d", c), cnt2[c], m_cnt[2][c]);
         chk($sformatf("d0_ovf%0d", c), ovf0[c], m_ovf[0][c]);
         chk($sformatf("d1_ovf%0d", c), ovf1[c], m_ovf[1][c]);
         chk($sformatf("d2_ovf%0d", c), ovf2[c], m_ovf[2][c]);
         chk($sformatf("d0_snap%0d", c), s0.snap_data_o[c], m_snap[0][c]);
         chk($sformatf("d1_snap%0d", c), s1.snap_data_o[c], m_snap[1][c]);
         chk($sformatf("d2_snap%0d", c), s2.snap_data_o[c], m_snap[2][c]);
         chk($sformatf("d0_sovf%0d", c), s0.snap_ovf_o[c], m_sovf[0][c]);
         chk($sformatf("d1_sovf%0d", c), s1.snap_ovf_o[c], m_sovf[1][c]);
         chk($sformatf("d2_sovf%0d", c), s2.snap_ovf_o[c], m_sovf[2][c]);
      end
      chk("d0_vld", s0.snap_valid_o, m_vld[0]);
      chk("d1_vld", s1.snap_valid_o, m_vld[1]);
      chk("d2_vld", s2.snap_valid_o, m_vld[2]);
      chk("d0_lost", s0.snap_lost_o, m_lost[0]);
      chk("d1_lost", s1.snap_lost_o, m_lost[1]);
      chk("d2_lost", s2.snap_lost_o, m_lost[2]);
   endtask

   // One clock: inputs are already driven; update model, then compare at negedge.
   task automatic cyc();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      rst = 0; ev = 2'b00; eop = 0; clr = 0; rdy = 0; en = 1; mask = 2'b11;
   endtask

   task automatic do_reset();
      idle(); rst = 1; cyc(); rst = 0;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         m_vld[d] = 0; m_lost[d] = 0;
         for (int c = 0; c < 2; c++) begin
            m_cnt[d][c] = 0; m_ovf[d][c] = 0; m_snap[d][c] = 0; m_sovf[d][c] = 0;
         end
      end
      idle();
      rst = 1;
      @(negedge clk);
      cyc(); cyc();
      chk("rst_cnt0", cnt0[0], 0);
      chk("rst_vld", s0.snap_valid_o, 0);
      chk("rst_lost", s0.snap_lost_o, 0);

      // channel counting, independent per channel
      idle();
      ev = 2'b01; repeat (5) cyc();
      ev = 2'b10; repeat (3) cyc();
      ev = 2'b00;
      chk("basic_c0", cnt0[0], 5);
      chk("basic_c1", cnt0[1], 3);
      chk("basic_ovf", ovf0, 0);

      // 4-bit overflow: wrap vs saturate
      do_reset();
      ev = 2'b01; repeat (17) cyc();
      ev = 2'b00;
      chk("wrap_cnt", cnt1[0], 1);
      chk("wrap_ovf", ovf1[0], 1);
      chk("sat_cnt", cnt2[0], 15);
      chk("sat_ovf", ovf2[0], 1);
      cyc();
      chk("ovf_sticky", ovf1[0], 1);

      // eop includes the same-cycle event; valid holds until handshake
      do_reset();
      ev = 2'b01; repeat (7) cyc();
      eop = 1; cyc();
      eop = 0; ev = 2'b00;
      chk("eop_vld", s0.snap_valid_o, 1);
      chk("eop_snap", s0.snap_data_o[0], 8);
      chk("eop_cnt", cnt0[0], 0);
      cyc(); cyc();
      chk("eop_hold", s0.snap_data_o[0], 8);
      rdy = 1; cyc();
      rdy = 0;
      chk("hs_vld", s0.snap_valid_o, 0);

      // overwritten snapshot raises lost; clear drops lost but keeps valid
      do_reset();
      ev = 2'b11; eop = 1; cyc();
      eop = 0; repeat (3) cyc();
      eop = 1; cyc();
      eop = 0; ev = 2'b00;
      chk("lost_set", s0.snap_lost_o, 1);
      chk("lost_snap", s0.snap_data_o[1], 4);
      clr = 1; cyc();
      clr = 0;
      chk("lost_clr", s0.snap_lost_o, 0);
      chk("clr_vld", s0.snap_valid_o, 1);

      // eop together with an accepted handshake: no loss
      rdy = 1; eop = 1; cyc();
      rdy = 0; eop = 0;
      chk("eop_hs_vld", s0.snap_valid_o, 1);
      chk("eop_hs_lost", s0.snap_lost_o, 0);

      // masking and global enable
      do_reset();
      mask = 2'b10; ev = 2'b11; repeat (4) cyc();
      chk("mask_c0", cnt0[0], 0);
      chk("mask_c1", cnt0[1], 4);
      en = 0; repeat (3) cyc();
      chk("en_off_c1", cnt0[1], 4);

      // reset mid-handshake with live counts
      en = 1; mask = 2'b11; eop = 1; cyc();
      eop = 0; repeat (2) cyc();
      chk("pre_rst_vld", s0.snap_valid_o, 1);
      rst = 1; cyc();
      rst = 0; ev = 2'b00;
      chk("rst2_cnt", cnt0[0], 0);
      chk("rst2_vld", s0.snap_valid_o, 0);
      chk("rst2_snap", s0.snap_data_o[1], 0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 127) == 0);
         ev   = 2'($urandom);
         mask = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
         en   = ($urandom_range(0, 7) != 0);
         eop  = ($urandom_range(0, 9) == 0);
         clr  = !eop && ($urandom_range(0, 19) == 0);
         rdy  = ($urandom_range(0, 2) == 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
